a2d_avg_seq: RTL and testbench

//  Conversion sequencer + averager for ss_A2D. Issues strt_cnv pulses at a fixed

---
 rtl/a2d_avg_seq_pkg.sv | 30 +++
 rtl/a2d_avg_seq_if.sv | 23 ++
 rtl/a2d_avg_seq_accum.sv | 61 ++++++
 rtl/a2d_avg_seq.sv | 170 +++++++++++++++++
 tb/tb_a2d_avg_seq.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/a2d_avg_seq_pkg.sv
// Shared types and helpers for the A2D conversion sequencer / averager.
package a2d_avg_seq_pkg;

    // Width of one ss_A2D conversion result.
    localparam int RESULT_W = 10;

    // Largest supported log2 sample count; sizes the rounding datapath.
    localparam int MAX_LOG2 = 6;

    // Wide enough for a full accumulator plus the rounding carry.
    localparam int SUM_W = RESULT_W + MAX_LOG2 + 1;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_CMPLT,
        ST_SETTLE,
        ST_GAP
    } seq_state_t;

    // Clamp a rounded average to the 10-bit result range.
    function automatic logic [RESULT_W-1:0] sat10(input logic [SUM_W-1:0] val);
        if (|val[SUM_W-1:RESULT_W]) begin
            return {RESULT_W{1'b1}};
        end
        return val[RESULT_W-1:0];
    endfunction

endpackage

// File: rtl/a2d_avg_seq_if.sv
// Handshake between the sequencer (master) and the ss_A2D converter (slave).
interface a2d_avg_seq_if;
    import a2d_avg_seq_pkg::*;

    logic                strt_cnv;
    logic                cnv_cmplt;
    logic [RESULT_W-1:0] result;

    // Sequencer side: requests conversions and reads results.
    modport master (
        output strt_cnv,
        input  cnv_cmplt,
        input  result
    );

    // Converter side: answers conversion requests.
    modport slave (
        input  strt_cnv,
        output cnv_cmplt,
        output result
    );

endinterface

// File: rtl/a2d_avg_seq_accum.sv
// Sample accumulator: sums 2**LOG2_SMPLS results and forms the rounded,
// saturated average from the running sum plus the sample being added.
module a2d_avg_seq_accum
    import a2d_avg_seq_pkg::*;
#(
    parameter int LOG2_SMPLS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                add,
    input  logic [RESULT_W-1:0] smpl,
    output logic [RESULT_W-1:0] avg_nxt,
    output logic                last_smpl
);

    localparam int ACC_W = RESULT_W + LOG2_SMPLS;
    localparam int CNT_W = (LOG2_SMPLS == 0) ? 1 : LOG2_SMPLS;

    logic [ACC_W-1:0] acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [ACC_W-1:0] sum;
    logic [SUM_W-1:0] rounded;

    // Accumulator is wide enough that the full block of samples never overflows.
    assign sum = acc_reg + ACC_W'(smpl);

    generate
        if (LOG2_SMPLS == 0) begin : g_pass
            // Single-sample "average": no rounding term, every sample is the last.
            assign rounded   = SUM_W'(sum);
            assign last_smpl = 1'b1;
        end else begin : g_avg
            // Add half an LSB before the shift so .5 rounds up.
            assign rounded   = (SUM_W'(sum) + SUM_W'(1 << (LOG2_SMPLS - 1))) >> LOG2_SMPLS;
            assign last_smpl = (cnt_reg == {CNT_W{1'b1}});
        end
    endgenerate

    assign avg_nxt = sat10(rounded);

    // Running sum and sample count; clear wins over add, block wraps on the last sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (clr) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (add) begin
            if (last_smpl) begin
                acc_reg <= '0;
                cnt_reg <= '0;
            end else begin
                acc_reg <= sum;
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/a2d_avg_seq.sv
// Conversion sequencer + averager for ss_A2D: paces strt_cnv pulses, captures
// each result on the rising edge of cnv_cmplt, and publishes a rounded average
// of every 2**LOG2_SMPLS samples with a one-clock avg_vld strobe.
module a2d_avg_seq
    import a2d_avg_seq_pkg::*;
#(
    parameter int LOG2_SMPLS = 2,
    parameter int GAP_CLKS   = 8,
    parameter int TIMEOUT    = 2048
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    a2d_avg_seq_if.master       a2d,
    output logic [RESULT_W-1:0] avg,
    output logic                avg_vld,
    output logic                busy,
    output logic                err
);

    localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int GAP_W = $clog2(GAP_CLKS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);

    seq_state_t          state_reg;
    logic                strt_cnv_reg;
    logic [RESULT_W-1:0] avg_reg;
    logic                avg_vld_reg;
    logic                busy_reg;
    logic                err_reg;
    logic                cmplt_ff_reg;
    logic                ready_reg;
    logic                drop_reg;
    logic [TMO_W-1:0]    tmo_cnt_reg;
    logic [GAP_W-1:0]    gap_cnt_reg;

    logic                cmplt_rise;
    logic                tmo_hit;
    logic                acc_add;
    logic                acc_clr;
    logic [RESULT_W-1:0] avg_nxt;
    logic                last_smpl;

    // Edge detect, timeout decision and accumulator strobes.
    always_comb begin
        cmplt_rise = a2d.cnv_cmplt & ~cmplt_ff_reg;
        // A rise in the final wait cycle still counts as a good sample.
        tmo_hit    = (state_reg == ST_WAIT_CMPLT) && !cmplt_rise && (tmo_cnt_reg == TMO_LAST);
        // Samples are only kept when en stayed high for the whole conversion.
        acc_add    = (state_reg == ST_SETTLE) && en && !drop_reg;
        // Any drop of en, a lost conversion or idling discards the partial block.
        acc_clr    = !en || (state_reg == ST_IDLE) || tmo_hit ||
                     ((state_reg == ST_SETTLE) && drop_reg);
    end

    // One flop of cnv_cmplt history so a level held high is not re-counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmplt_ff_reg <= 1'b0;
        end else begin
            cmplt_ff_reg <= a2d.cnv_cmplt;
        end
    end

    // Holds off the first conversion for one clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_reg <= 1'b0;
        end else begin
            ready_reg <= 1'b1;
        end
    end

    a2d_avg_seq_accum #(
        .LOG2_SMPLS (LOG2_SMPLS)
    ) u_accum (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (acc_clr),
        .add       (acc_add),
        .smpl      (a2d.result),
        .avg_nxt   (avg_nxt),
        .last_smpl (last_smpl)
    );

    // Sequencer FSM with registered strt_cnv / avg / avg_vld / busy / err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            strt_cnv_reg <= 1'b0;
            avg_reg      <= '0;
            avg_vld_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            err_reg      <= 1'b0;
            drop_reg     <= 1'b0;
            tmo_cnt_reg  <= '0;
            gap_cnt_reg  <= '0;
        end else begin
            strt_cnv_reg <= 1'b0;
            avg_vld_reg  <= 1'b0;
            err_reg      <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (en && ready_reg) begin
                        state_reg    <= ST_START;
                        strt_cnv_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                        drop_reg     <= 1'b0;
                    end
                end
                ST_START: begin
                    tmo_cnt_reg <= '0;
                    state_reg   <= ST_WAIT_CMPLT;
                    if (!en) begin
                        drop_reg <= 1'b1;
                    end
                end
                ST_WAIT_CMPLT: begin
                    // The conversion always runs to completion even if en falls.
                    if (!en) begin
                        drop_reg <= 1'b1;
                    end
                    if (cmplt_rise) begin
                        state_reg <= ST_SETTLE;
                    end else if (tmo_hit) begin
                        err_reg     <= 1'b1;
                        gap_cnt_reg <= '0;
                        state_reg   <= ST_GAP;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (acc_add && last_smpl) begin
                        avg_reg     <= avg_nxt;
                        avg_vld_reg <= 1'b1;
                    end
                    gap_cnt_reg <= '0;
                    state_reg   <= ST_GAP;
                end
                ST_GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        if (en) begin
                            state_reg    <= ST_START;
                            strt_cnv_reg <= 1'b1;
                            drop_reg     <= 1'b0;
                        end else begin
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign a2d.strt_cnv = strt_cnv_reg;
    assign avg          = avg_reg;
    assign avg_vld      = avg_vld_reg;
    assign busy         = busy_reg;
    assign err          = err_reg;

endmodule

// File: tb/tb_a2d_avg_seq.sv
// Self-checking bench for a2d_avg_seq with a behavioural ss_A2D model.
// Cycle bookkeeping (cyc counts negedges): a conversion started in cycle S
// raises cnv_cmplt in cycle R = S + conv_time; the average appears in R+2 and
// the next strt_cnv in R+2+GAP. A lost conversion reports err in S+TMO+1 and
// restarts in S+TMO+1+GAP.
module tb_a2d_avg_seq;
    import a2d_avg_seq_pkg::*;

    localparam int L   = 2;
    localparam int N   = 1 << L;
    localparam int GAP = 8;
    localparam int TMO = 2048;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [9:0] avg;
    logic       avg_vld;
    logic       busy;
    logic       err;

    a2d_avg_seq_if bus();

    a2d_avg_seq #(
        .LOG2_SMPLS (L),
        .GAP_CLKS   (GAP),
        .TIMEOUT    (TMO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .a2d     (bus),
        .avg     (avg),
        .avg_vld (avg_vld),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int conv_time = 4;
    bit mute = 0;
    int cd = 0;
    logic [9:0] val_q[$];
    int group[$];
    int exp_strt = -1;          // -1: any time allowed, -2: none allowed
    int exp_err = -1;
    int exp_vld = -1;
    int exp_avg = 0;
    int rises = 0, vlds = 0, errs = 0, strts = 0;
    int rel_cyc = 0;
    bit first_after_rst = 0;
    int last_rise = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference average of one block: round half up, clamp to 10 bits.
    function automatic int ref_avg(input int s);
        int a;
        a = (s + N / 2) / N;
        return (a > 1023) ? 1023 : a;
    endfunction

    // Advance one cycle: run the converter model and check output events.
    task automatic tick();
        logic [9:0] v;
        int s;
        @(negedge clk);
        cyc++;
        if (bus.strt_cnv === 1'b1) begin
            strts++;
            if (exp_strt == -1) begin
                if (first_after_rst) begin
                    chk("strt_after_rst", 32'(cyc - rel_cyc >= 2), 1);
                    first_after_rst = 0;
                end
            end else begin
                chk("strt_time", cyc, exp_strt);
            end
            bus.cnv_cmplt = 1'b0;
            if (mute) begin
                cd = 0;
                group.delete();
                exp_err  = cyc + TMO + 1;
                exp_strt = exp_err + GAP;
            end else begin
                cd = conv_time;
                exp_strt = -2;
            end
        end else begin
            if (exp_strt >= 0 && cyc == exp_strt) chk("strt_missing", 0, 1);
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    v = (val_q.size() > 0) ? val_q.pop_front() : 10'($urandom_range(0, 1023));
                    bus.result = v;
                    bus.cnv_cmplt = 1'b1;
                    rises++;
                    last_rise = cyc;
                    if (en) begin
                        group.push_back(int'(v));
                        if (group.size() == N) begin
                            s = 0;
                            foreach (group[i]) s += group[i];
                            exp_avg = ref_avg(s);
                            exp_vld = cyc + 2;
                            group.delete();
                        end
                        exp_strt = cyc + 2 + GAP;
                    end
                end
            end
        end
        if (avg_vld === 1'b1) begin
            vlds++;
            chk("vld_time", cyc, exp_vld);
            chk("avg_value", 32'(avg), exp_avg);
            chk("busy_at_vld", 32'(busy), 1);
            exp_vld = -1;
        end else if (exp_vld >= 0 && cyc == exp_vld) begin
            chk("vld_missing", 0, 1);
        end
        if (err === 1'b1) begin
            errs++;
            chk("err_time", cyc, exp_err);
            exp_err = -1;
            mute = 0;
        end else if (exp_err >= 0 && cyc == exp_err) begin
            chk("err_missing", 0, 1);
        end
    endtask

    task automatic wait_vld(input int target, input string tag);
        int b = 0;
        while (vlds < target && b < 4000) begin
            tick();
            b++;
        end
        chk(tag, vlds, target);
    endtask

    initial begin
        int b;
        int base;
        logic [9:0] saved_avg;

        bus.cnv_cmplt = 1'b0;
        bus.result = '0;
        rst_n = 1'b0;
        en = 1'b1;

        // Reset held for three clocks: every output quiet.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_outputs", 32'({bus.strt_cnv, avg, avg_vld, busy, err}), 0);
        end
        rst_n = 1'b1;
        rel_cyc = cyc;
        first_after_rst = 1;
        exp_strt = -1;

        // Basic block average.
        conv_time = 5;
        val_q.push_back(10'h100); val_q.push_back(10'h101);
        val_q.push_back(10'h102); val_q.push_back(10'h101);
        wait_vld(1, "basic_block_done");
        $display("tb: basic avg=%03h", avg);

        // Half-LSB rounds up.
        conv_time = 3;
        val_q.push_back(10'h000); val_q.push_back(10'h000);
        val_q.push_back(10'h000); val_q.push_back(10'h002);
        wait_vld(2, "round_block_done");
        $display("tb: round avg=%03h", avg);

        // Full-scale samples stay at full scale.
        for (int i = 0; i < 4; i++) val_q.push_back(10'h3FF);
        wait_vld(3, "fullscale_block_done");
        $display("tb: fullscale avg=%03h", avg);

        // Lost conversion: err, restart, then a clean block.
        mute = 1;
        b = 0;
        while (errs < 1 && b < TMO + 200) begin
            tick();
            b++;
        end
        chk("err_seen", errs, 1);
        $display("tb: timeout err at cyc=%0d", cyc);
        wait_vld(4, "post_timeout_block_done");
        $display("tb: post-timeout avg=%03h", avg);

        // Random blocks with random conversion times.
        for (int g = 0; g < 3; g++) begin
            conv_time = $urandom_range(1, 12);
            wait_vld(5 + g, "random_block_done");
            $display("tb: random block %0d conv=%0d avg=%03h", g, conv_time, avg);
        end

        // Drop en after the second sample of a block.
        base = rises;
        b = 0;
        while (rises < base + 2 && b < 200) begin
            tick();
            b++;
        end
        chk("two_samples_seen", rises, base + 2);
        tick();
        tick();
        en = 1'b0;
        group.delete();
        exp_strt = -2;
        saved_avg = avg;
        while (cyc < last_rise + 1 + GAP) tick();
        chk("busy_last_gap", 32'(busy), 1);
        tick();
        chk("busy_fell", 32'(busy), 0);
        repeat (20) tick();
        chk("avg_held", 32'(avg), 32'(saved_avg));
        chk("idle_busy", 32'(busy), 0);
        $display("tb: en drop, avg held=%03h", avg);

        // Re-enable: a fresh block from a cleared accumulator.
        en = 1'b1;
        exp_strt = -1;
        wait_vld(vlds + 1, "reenable_block_done");
        $display("tb: re-enable avg=%03h", avg);

        // Asynchronous reset in the middle of a conversion.
        conv_time = 10;
        base = strts;
        b = 0;
        while (strts == base && b < 100) begin
            tick();
            b++;
        end
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", 32'({bus.strt_cnv, avg, avg_vld, busy, err}), 0);
        cd = 0;
        bus.cnv_cmplt = 1'b0;
        group.delete();
        exp_vld = -1;
        exp_strt = -1;
        tick();
        tick();
        chk("reset_hold_outputs", 32'({bus.strt_cnv, avg, avg_vld, busy, err}), 0);
        rst_n = 1'b1;
        rel_cyc = cyc;
        first_after_rst = 1;
        base = strts;
        b = 0;
        while (strts == base && b < 10) begin
            tick();
            b++;
        end
        chk("restart_after_reset", strts, base + 1);
        $display("tb: restart after async reset at cyc=%0d", cyc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
